// File: rtl/tpu_tile_sequencer.sv
// Purpose : sequences one matmul job over num_tiles weight tiles (FIFO pop, weight reload, UB row stream, result-SRAM writes).
// Latency : start->first pop 2 cycles when weights are present; first UB row to first result write = RESULT_LATENCY cycles.
// Backpressure: stalls in WAIT_W while fifo_empty=1; abort returns to IDLE next cycle, async reset immediately.
// Ports   : clk/rstn; start/abort/num_tiles/ub_base/res_base job control; fifo_empty in;
//           fifo_read_enable, we_rl, ub_read_en/ub_address, res_write_enable/res_address, tile_idx, busy, done out.
module tpu_tile_sequencer #(
    parameter int ADDRESSSIZE    = 10,
    parameter int MATRIX_SIZE    = 32,
    parameter int RESULT_LATENCY = 64,
    parameter int TILE_BW        = 8,
    parameter int CNT_BW         = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   abort,
    input  logic [TILE_BW-1:0]     num_tiles,
    input  logic [ADDRESSSIZE-1:0] ub_base,
    input  logic [ADDRESSSIZE-1:0] res_base,
    input  logic                   fifo_empty,
    output logic                   fifo_read_enable,
    output logic                   we_rl,
    output logic                   ub_read_en,
    output logic [ADDRESSSIZE-1:0] ub_address,
    output logic                   res_write_enable,
    output logic [ADDRESSSIZE-1:0] res_address,
    output logic [TILE_BW-1:0]     tile_idx,
    output logic                   busy,
    output logic                   done
);

    localparam logic [CNT_BW-1:0]      C_ROW_LAST = CNT_BW'(MATRIX_SIZE - 1);
    localparam logic [CNT_BW-1:0]      C_LAT      = CNT_BW'(RESULT_LATENCY);
    localparam logic [CNT_BW-1:0]      C_WIN_LAST = CNT_BW'(RESULT_LATENCY + MATRIX_SIZE - 1);
    localparam logic [ADDRESSSIZE-1:0] C_M_ADDR   = ADDRESSSIZE'(MATRIX_SIZE);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_W, S_POP, S_RELOAD, S_STREAM, S_DRAIN, S_DONE
    } state_t;

    state_t                 r_state;
    logic [TILE_BW-1:0]     r_num_tiles;
    logic [ADDRESSSIZE-1:0] r_ub_base;
    logic [ADDRESSSIZE-1:0] r_res_base;
    logic [ADDRESSSIZE-1:0] r_tile_off;   // running tile_idx*M, avoids a multiplier
    logic [TILE_BW-1:0]     r_tile_idx;
    logic [CNT_BW-1:0]      r_row;
    logic [CNT_BW-1:0]      r_wcnt;       // cycles since first STREAM cycle of this tile
    logic                   r_win_active;
    logic                   r_fifo_re;
    logic                   r_we_rl;
    logic                   r_ub_rd;
    logic [ADDRESSSIZE-1:0] r_ub_addr;
    logic                   r_res_we;
    logic [ADDRESSSIZE-1:0] r_res_addr;
    logic                   r_busy;
    logic                   r_done;

    logic [CNT_BW-1:0]      w_wcnt_nxt;
    logic                   w_win_nxt;
    logic [ADDRESSSIZE-1:0] w_res_addr_nxt;
    logic [CNT_BW-1:0]      w_row_nxt;
    logic [ADDRESSSIZE-1:0] w_ub_addr_first;
    logic [ADDRESSSIZE-1:0] w_ub_addr_nxt;
    logic [TILE_BW:0]       w_tile_inc;
    logic                   w_more_tiles;

    // Outputs are registered, so each is computed for the cycle after the edge.
    assign w_wcnt_nxt      = r_wcnt + 1'b1;
    assign w_win_nxt       = r_win_active && (r_wcnt != C_WIN_LAST) && (w_wcnt_nxt >= C_LAT);
    assign w_res_addr_nxt  = r_res_base + r_tile_off + ADDRESSSIZE'(w_wcnt_nxt - C_LAT);
    assign w_row_nxt       = r_row + 1'b1;
    assign w_ub_addr_first = r_ub_base + r_tile_off;
    assign w_ub_addr_nxt   = r_ub_base + r_tile_off + ADDRESSSIZE'(w_row_nxt);
    assign w_tile_inc      = {1'b0, r_tile_idx} + (TILE_BW+1)'(1);
    assign w_more_tiles    = w_tile_inc < {1'b0, r_num_tiles};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_num_tiles  <= '0;
            r_ub_base    <= '0;
            r_res_base   <= '0;
            r_tile_off   <= '0;
            r_tile_idx   <= '0;
            r_row        <= '0;
            r_wcnt       <= '0;
            r_win_active <= 1'b0;
            r_fifo_re    <= 1'b0;
            r_we_rl      <= 1'b0;
            r_ub_rd      <= 1'b0;
            r_ub_addr    <= '0;
            r_res_we     <= 1'b0;
            r_res_addr   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else if (abort) begin
            // Kills the in-flight write window too; no done pulse.
            r_state      <= S_IDLE;
            r_tile_off   <= '0;
            r_tile_idx   <= '0;
            r_row        <= '0;
            r_wcnt       <= '0;
            r_win_active <= 1'b0;
            r_fifo_re    <= 1'b0;
            r_we_rl      <= 1'b0;
            r_ub_rd      <= 1'b0;
            r_ub_addr    <= '0;
            r_res_we     <= 1'b0;
            r_res_addr   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_fifo_re <= 1'b0;
            r_we_rl   <= 1'b0;
            r_done    <= 1'b0;

            // Result window runs off its own counter so it can overlap STREAM.
            if (r_win_active) begin
                r_res_we   <= w_win_nxt;
                r_res_addr <= w_win_nxt ? w_res_addr_nxt : '0;
                if (r_wcnt == C_WIN_LAST) begin
                    r_win_active <= 1'b0;
                    r_wcnt       <= '0;
                end else begin
                    r_wcnt <= w_wcnt_nxt;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (num_tiles != '0) begin
                            r_num_tiles <= num_tiles;
                            r_ub_base   <= ub_base;
                            r_res_base  <= res_base;
                            r_tile_idx  <= '0;
                            r_tile_off  <= '0;
                            r_busy      <= 1'b1;
                            r_state     <= S_WAIT_W;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_WAIT_W: begin
                    if (!fifo_empty) begin
                        r_fifo_re <= 1'b1;
                        r_state   <= S_POP;
                    end
                end
                S_POP: begin
                    r_we_rl <= 1'b1;
                    r_state <= S_RELOAD;
                end
                S_RELOAD: begin
                    r_ub_rd      <= 1'b1;
                    r_ub_addr    <= w_ub_addr_first;
                    r_row        <= '0;
                    r_wcnt       <= '0;
                    r_win_active <= 1'b1;
                    r_res_we     <= 1'b0;
                    r_res_addr   <= '0;
                    r_state      <= S_STREAM;
                end
                S_STREAM: begin
                    if (r_row == C_ROW_LAST) begin
                        r_ub_rd   <= 1'b0;
                        r_ub_addr <= '0;
                        r_row     <= '0;
                        r_state   <= S_DRAIN;
                    end else begin
                        r_row     <= w_row_nxt;
                        r_ub_addr <= w_ub_addr_nxt;
                    end
                end
                S_DRAIN: begin
                    // Leave on the cycle carrying the last write of this tile.
                    if (r_win_active && (r_wcnt == C_WIN_LAST)) begin
                        if (w_more_tiles) begin
                            r_tile_idx <= w_tile_inc[TILE_BW-1:0];
                            r_tile_off <= r_tile_off + C_M_ADDR;
                            r_state    <= S_WAIT_W;
                        end else begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign fifo_read_enable = r_fifo_re;
    assign we_rl            = r_we_rl;
    assign ub_read_en       = r_ub_rd;
    assign ub_address       = r_ub_addr;
    assign res_write_enable = r_res_we;
    assign res_address      = r_res_addr;
    assign tile_idx         = r_tile_idx;
    assign busy             = r_busy;
    assign done             = r_done;

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
module tb_tpu_tile_sequencer;

    localparam int AW  = 10;
    localparam int M   = 4;
    localparam int L   = 6;
    localparam int TBW = 8;
    localparam int CBW = 8;
    localparam int N   = 512;

    logic           clk        = 1'b0;
    logic           rstn       = 1'b0;
    logic           start      = 1'b0;
    logic           abort      = 1'b0;
    logic [TBW-1:0] num_tiles  = '0;
    logic [AW-1:0]  ub_base    = '0;
    logic [AW-1:0]  res_base   = '0;
    logic           fifo_empty = 1'b1;

    logic           fifo_read_enable;
    logic           we_rl;
    logic           ub_read_en;
    logic [AW-1:0]  ub_address;
    logic           res_write_enable;
    logic [AW-1:0]  res_address;
    logic [TBW-1:0] tile_idx;
    logic           busy;
    logic           done;

    tpu_tile_sequencer #(
        .ADDRESSSIZE   (AW),
        .MATRIX_SIZE   (M),
        .RESULT_LATENCY(L),
        .TILE_BW       (TBW),
        .CNT_BW        (CBW)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .start           (start),
        .abort           (abort),
        .num_tiles       (num_tiles),
        .ub_base         (ub_base),
        .res_base        (res_base),
        .fifo_empty      (fifo_empty),
        .fifo_read_enable(fifo_read_enable),
        .we_rl           (we_rl),
        .ub_read_en      (ub_read_en),
        .ub_address      (ub_address),
        .res_write_enable(res_write_enable),
        .res_address     (res_address),
        .tile_idx        (tile_idx),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int job_no   = 0;
    logic [TBW-1:0] prev_tile = '0;

    // Per-cycle stimulus and expected outputs, indexed by cycles after the start edge.
    bit             fe     [N];
    bit             st     [N];
    bit             e_pop  [N];
    bit             e_rl   [N];
    bit             e_ub   [N];
    bit             e_we   [N];
    bit             e_busy [N];
    bit             e_done [N];
    logic [AW-1:0]  e_ua   [N];
    logic [AW-1:0]  e_ra   [N];
    logic [TBW-1:0] e_tile [N];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [63:0] pack(input bit d, input bit b, input logic [TBW-1:0] t,
                                         input bit we, input logic [AW-1:0] ra, input bit ub,
                                         input logic [AW-1:0] ua, input bit rl, input bit pop);
        return {30'b0, d, b, t, we, ra, ub, ua, rl, pop};
    endfunction

    // Addresses are compared only where the model expects the matching strobe.
    function automatic logic [63:0] observe(input bit mask_ub, input bit mask_we);
        return pack(done, busy, tile_idx, res_write_enable, mask_we ? res_address : '0,
                    ub_read_en, mask_ub ? ub_address : '0, we_rl, fifo_read_enable);
    endfunction

    task automatic run_job(input int nt, input logic [AW-1:0] ub, input logic [AW-1:0] rb,
                           input int stall_pct, input int stall_to, input int abort_at,
                           input int rst_at, input int start_pct, input int force_st);
        int ws, w, p, d, cut, last, st_lim;
        job_no++;
        for (int j = 0; j < N; j++) begin
            fe[j]     = (j >= 1 && j < 300 && ($urandom_range(99) < stall_pct)) || (j >= 1 && j <= stall_to);
            st[j]     = 1'b0;
            e_pop[j]  = 1'b0; e_rl[j] = 1'b0; e_ub[j] = 1'b0; e_we[j] = 1'b0;
            e_busy[j] = 1'b0; e_done[j] = 1'b0;
            e_ua[j]   = '0;   e_ra[j] = '0;   e_tile[j] = prev_tile;
        end
        // Timeline: tile waits for the first non-empty cycle, pops next cycle,
        // reloads, streams M rows, and writes M rows L cycles after the first row.
        ws = 1;
        for (int i = 0; i < nt; i++) begin
            w = ws;
            while (w < N - 1 && fe[w]) w++;
            p = w + 1;
            for (int j = ws; j < p + 2 + L + M; j++) e_tile[j] = TBW'(i);
            e_pop[p]     = 1'b1;
            e_rl[p + 1]  = 1'b1;
            for (int r = 0; r < M; r++) begin
                e_ub[p + 2 + r] = 1'b1;
                e_ua[p + 2 + r] = ub + AW'(i * M + r);
            end
            for (int k = 0; k < M; k++) begin
                e_we[p + 2 + L + k] = 1'b1;
                e_ra[p + 2 + L + k] = rb + AW'(i * M + k);
            end
            ws = p + 2 + L + M;
        end
        d = (nt == 0) ? 1 : ws;
        for (int j = 1; j < d; j++) e_busy[j] = 1'b1;
        e_done[d] = 1'b1;
        if (nt != 0) for (int j = d; j < N; j++) e_tile[j] = TBW'(nt - 1);

        if (abort_at < 0) abort_at = (d > 1) ? int'($urandom_range(d - 1, 1)) : 0;
        cut = (abort_at > 0) ? abort_at : ((rst_at > 0) ? rst_at - 1 : 0);
        if (cut > 0) begin
            for (int j = cut + 1; j < N; j++) begin
                e_pop[j] = 1'b0; e_rl[j] = 1'b0; e_ub[j] = 1'b0; e_we[j] = 1'b0;
                e_busy[j] = 1'b0; e_done[j] = 1'b0; e_ua[j] = '0; e_ra[j] = '0; e_tile[j] = '0;
            end
        end
        last   = (cut > 0) ? cut + 4 : d + 3;
        st_lim = (cut > 0) ? cut : d;
        for (int j = 1; j <= st_lim; j++) st[j] = ($urandom_range(99) < start_pct);
        if (force_st > 0 && force_st <= st_lim) st[force_st] = 1'b1;

        @(negedge clk);
        start = 1'b1; num_tiles = TBW'(nt); ub_base = ub; res_base = rb;
        fifo_empty = fe[0]; abort = 1'b0;
        for (int j = 1; j <= last; j++) begin
            @(posedge clk);
            #1;
            start      = st[j];
            fifo_empty = fe[j];
            abort      = (abort_at == j);
            num_tiles  = TBW'($urandom);
            ub_base    = AW'($urandom);
            res_base   = AW'($urandom);
            if (rst_at == j) begin
                #2;
                rstn = 1'b0;
                #1;
                chk($sformatf("job%0d_async_rst", job_no), observe(1'b1, 1'b1), 64'd0);
            end
            @(negedge clk);
            chk($sformatf("job%0d_cyc%0d", job_no, j), observe(e_ub[j], e_we[j]),
                pack(e_done[j], e_busy[j], e_tile[j], e_we[j], e_ra[j], e_ub[j], e_ua[j], e_rl[j], e_pop[j]));
            if (rst_at > 0 && j == rst_at + 1) rstn = 1'b1;
        end
        start = 1'b0;
        abort = 1'b0;
        if (cut > 0) prev_tile = '0;
        else if (nt != 0) prev_tile = TBW'(nt - 1);
    endtask

    initial begin
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", observe(1'b1, 1'b1), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_reset", observe(1'b1, 1'b1), 64'd0);

        // basic two-tile job
        run_job(2, 10'h010, 10'h100, 0, 0, 0, 0, 0, 0);
        // weight FIFO empty for four WAIT_W cycles
        run_job(2, 10'h010, 10'h100, 0, 4, 0, 0, 0, 0);
        // zero tiles
        run_job(0, 10'h055, 10'h0AA, 0, 0, 0, 0, 0, 0);
        // address wrap
        run_job(1, 10'h3FE, 10'h3FF, 0, 0, 0, 0, 0, 0);
        // abort in the write window, then a clean rerun
        run_job(2, 10'h010, 10'h100, 0, 0, 11, 0, 0, 0);
        run_job(2, 10'h010, 10'h100, 0, 0, 0, 0, 0, 0);
        // start while busy, then async reset mid-job
        run_job(2, 10'h010, 10'h100, 0, 0, 0, 8, 0, 5);
        // randomized jobs
        for (int n = 0; n < 30; n++) begin
            run_job(int'($urandom_range(3)), AW'($urandom), AW'($urandom),
                    int'($urandom_range(60)), 0, ($urandom_range(3) == 0) ? -1 : 0,
                    0, int'($urandom_range(25)), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tpu_tile_sequencer.md
Name: tpu_tile_sequencer

Overview:
- Sequences one matrix-multiply job across multiple weight tiles: weight FIFO pop, systolic weight reload, Unified Buffer row streaming and result-SRAM row writes.
- Sits beside the TPU top; drives fifo_read_enable, we_rl, the UB address and the result-SRAM write port that are otherwise driven from pins or free-running counters.
- Tiles are processed strictly one after another; a tile finishes its last result write before the next weight pop.

Parameters:
ADDRESSSIZE, 10, UB and result-SRAM address width
MATRIX_SIZE, 32, rows streamed and written per tile (M)
RESULT_LATENCY, 64, cycles from first UB address issue to first result write (L, must be >= 1)
TILE_BW, 8, width of the tile count
CNT_BW, 8, width of the internal latency/row counters (must hold L+M)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  job request, sampled in IDLE only
abort  in  1  synchronous abort, returns to IDLE
num_tiles  in  TILE_BW  tiles in the job, latched at start
ub_base  in  ADDRESSSIZE  first UB row address, latched at start
res_base  in  ADDRESSSIZE  first result row address, latched at start
fifo_empty  in  1  weight FIFO empty flag
fifo_read_enable  out  1  one-cycle weight FIFO pop
we_rl  out  1  one-cycle systolic weight reload
ub_read_en  out  1  UB row address valid
ub_address  out  ADDRESSSIZE  UB row address
res_write_enable  out  1  result-SRAM write strobe
res_address  out  ADDRESSSIZE  result-SRAM row address
tile_idx  out  TILE_BW  current tile index
busy  out  1  job in progress
done  out  1  one-cycle job-complete pulse

Behaviour:
- Reset: state IDLE; every output 0; all counters and latched registers 0.
- All outputs are decoded from registered state and counters only. There is no combinational path from any input to any output.
- IDLE:
  - start=1 with num_tiles!=0: latch num_tiles, ub_base and res_base; set tile_idx=0; go to WAIT_W.
  - start=1 with num_tiles=0: go directly to DONE.
- WAIT_W: busy=1. Move to POP on the first cycle with fifo_empty=0; otherwise stall indefinitely.
- POP: fifo_read_enable=1 for exactly one cycle, then go to RELOAD.
- RELOAD: we_rl=1 for exactly one cycle, then go to STREAM.
- STREAM: M cycles with ub_read_en=1.
  - ub_address = ub_base + tile_idx*M + row, for row = 0..M-1.
  - The first STREAM cycle is cycle S.
  - After row M-1, go to DRAIN.
- Result write window (independent counter started at S):
  - res_write_enable=1 on cycles S+L .. S+L+M-1.
  - res_address = res_base + tile_idx*M + k, for k = 0..M-1.
  - If L < M, the window overlaps STREAM; this is legal.
- DRAIN: busy=1, wait for the cycle carrying write k=M-1. On that same cycle:
  - if tile_idx+1 < num_tiles, increment tile_idx and go to WAIT_W;
  - otherwise go to DONE.
- DONE: done=1 for one cycle with busy=0, then go to IDLE. tile_idx holds its value until the next start.
- Address arithmetic is modulo 2^ADDRESSSIZE and wraps silently; no error is flagged.
- start while not in IDLE is ignored. start in the DONE cycle is ignored.
- abort=1 in any state:
  - next cycle is IDLE and all outputs are 0, including any in-flight write window;
  - done is not pulsed;
  - abort has priority over every other transition.
- Asynchronous reset mid-job: immediate return to the reset state; no further writes or pops.
- fifo_empty is ignored outside WAIT_W.

Test Plan:
(Bench uses MATRIX_SIZE=4, RESULT_LATENCY=6; E is the edge that samples start.)
1. Basic two-tile job: num_tiles=2, ub_base=0x010, res_base=0x100, fifo_empty=0, start pulse at E ->
   - tile 0: POP at E+2, RELOAD at E+3, ub_address 0x010..0x013 at E+4..E+7, writes 0x100..0x103 at E+10..E+13;
   - tile 1: POP at E+15, UB 0x014..0x017 at E+17..E+20, writes 0x104..0x107 at E+23..E+26;
   - done at E+27, busy=0 from E+27.
2. FIFO stall: same job with fifo_empty=1 held until E+5 -> POP first at E+6; every later event shifts by +4; no UB reads before POP.
3. num_tiles=0 with start -> done at E+1, busy never high, fifo_read_enable/we_rl/ub_read_en/res_write_enable never high.
4. Address wrap: ub_base=0x3FE, res_base=0x3FF, num_tiles=1 -> ub_address 0x3FE, 0x3FF, 0x000, 0x001; res_address 0x3FF, 0x000, 0x001, 0x002.
5. Abort during the write window: assert abort at E+11 of case 1 -> state IDLE at E+12, res_write_enable=0 from E+12, no done pulse, tile_idx=0. A fresh start then runs case 1 timing exactly.
6. Repeated start while busy at E+5 ignored; rstn low at E+8 -> all outputs 0 asynchronously; after release, idle until the next start.
